// File: rtl/bcd_binary_pkg.sv
// Shared types and constants for the 3-digit BCD to 10-bit binary converter.
package bcd_binary_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BIN_W      = 10;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned NUM_SHIFTS = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WORK_W     = BCD_W * NUM_DIGITS + BIN_W;

  localparam logic [BCD_W-1:0] MAX_DIGIT    = BCD_W'(9);
  localparam logic [BCD_W-1:0] DIGIT_THRESH = BCD_W'(8);
  localparam logic [BCD_W-1:0] DIGIT_ADJ    = BCD_W'(3);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic digit_valid(input logic [BCD_W-1:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble correction for one BCD field: subtract 3 when the field is >= 8.
module bcd_digit_correct
  import bcd_binary_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_c_o
);

  assign digit_c_o = (digit_i >= DIGIT_THRESH) ? digit_i - DIGIT_ADJ : digit_i;

endmodule

// File: rtl/bcd_binary.sv
// Sequential 3-digit BCD to binary converter: one right shift plus per-digit
// correction per cycle, ten cycles per conversion; bad digits are rejected.
module bcd_binary
  import bcd_binary_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BCD_W-1:0] hundredsplace,
  input  logic [BCD_W-1:0] tensplace,
  input  logic [BCD_W-1:0] onesplace,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] tenbitbinary
);

  state_e                             state_q, state_d;
  logic [WORK_W-1:0]                  work_q, work_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;
  logic [BIN_W-1:0]                   bin_q, bin_d;

  logic [WORK_W-1:0]                  shifted;
  logic [BCD_W*NUM_DIGITS-1:0]        corr_digits;
  logic [WORK_W-1:0]                  corrected;
  logic                               digits_ok;

  assign shifted   = work_q >> 1;
  assign corrected = {corr_digits, shifted[BIN_W-1:0]};
  assign digits_ok = digit_valid(hundredsplace) && digit_valid(tensplace) &&
                     digit_valid(onesplace);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_correct u_correct (
      .digit_i   (shifted[BIN_W + g*BCD_W +: BCD_W]),
      .digit_c_o (corr_digits[g*BCD_W +: BCD_W])
    );
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (digits_ok) begin
            work_d  = {hundredsplace, tensplace, onesplace, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = corrected;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_SHIFTS - 1)) begin
          bin_d   = corrected[BIN_W-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tenbitbinary = bin_q;

endmodule

// File: tb/tb_bcd_binary.sv
// Scoreboard bench for bcd_binary: driver queues expected results, monitor checks on done.
module tb_bcd_binary;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] hundredsplace, tensplace, onesplace;
  logic       busy, done, err;
  logic [9:0] tenbitbinary;

  bcd_binary dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .hundredsplace (hundredsplace),
    .tensplace     (tensplace),
    .onesplace     (onesplace),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .tenbitbinary  (tenbitbinary)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic err;
    int   val;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   last_val = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (err && !done) chk("err_without_done", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("err_flag", int'(err), int'(e.err));
          chk("result", int'(tenbitbinary), e.val);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // Pulse start for one cycle from a negedge; queue the expected response
  task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    exp_t e;
    hundredsplace = h;
    tensplace     = t;
    onesplace     = o;
    start         = 1'b1;
    if (h <= 4'd9 && t <= 4'd9 && o <= 4'd9) begin
      last_val = int'(h) * 100 + int'(t) * 10 + int'(o);
      e.err = 1'b0;
      e.val = last_val;
      e.cyc = cyc + 11;
    end else begin
      e.err = 1'b1;
      e.val = last_val;
      e.cyc = cyc + 1;
    end
    q.push_back(e);
    @(negedge clk);
    start         = 1'b0;
    hundredsplace = 4'hA;
    tensplace     = 4'hB;
    onesplace     = 4'hC;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    hundredsplace = '0;
    tensplace = '0;
    onesplace = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bin", int'(tenbitbinary), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 999
    issue(4'd9, 4'd9, 4'd9);
    chk("busy_during", int'(busy), 1);
    wait_done();

    // 000 then 255 back-to-back on the done cycle
    issue(4'd0, 4'd0, 4'd0);
    wait_done();
    issue(4'd2, 4'd5, 4'd5);
    wait_done();

    // Rejected request: done+err next cycle, busy never high, value held
    @(negedge clk);
    issue(4'd1, 4'd10, 4'd3);
    chk("err_busy0", int'(busy), 0);
    @(negedge clk);
    chk("err_busy1", int'(busy), 0);
    chk("err_done_single", int'(done), 0);

    // Start while busy is ignored
    issue(4'd1, 4'd2, 4'd3);
    repeat (3) @(negedge clk);
    hundredsplace = 4'd4;
    tensplace     = 4'd5;
    onesplace     = 4'd6;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);

    // Reset in the middle of a conversion
    issue(4'd5, 4'd0, 4'd0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_bin", int'(tenbitbinary), 0);
    q.delete();
    last_val = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", q.size(), 0);
    issue(4'd0, 4'd4, 4'd2);
    wait_done();

    // Exhaustive sweep
    for (int v = 0; v < 1000; v++) begin
      issue(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
